// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit
//   Chunk-serial two's-complement adder/subtractor. Each clock it adds one
//   K-bit slice of the operands, so an N = W/K cycle operation reuses a
//   single narrow adder for any operand width W.
//
// Parameters
//   W  operand/result width (W >= 2)
//   K  bits processed per cycle (1 <= K <= W, W % K == 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands A/B/sub valid
//   in_ready   unit is idle and can accept operands
//   A, B       signed operands (W bits)
//   sub        0: S = A + B, 1: S = A - B
//   out_valid  S/cout/ovf valid, held until out_ready
//   out_ready  consumer accepts the result
//   S          W-bit result
//   cout       carry out of bit W-1 (for subtraction 1 = no borrow)
//   ovf        signed overflow
//   busy       operation in progress or result waiting
//
// Configuration
//   ADDSUB_SAT_EN  when defined, an overflowing result is replaced by the
//                  saturated value on the final RUN edge; otherwise S wraps.

module serial_addsub_unit #(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int N  = W / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject parameter sets that cannot be split into whole chunks.
  generate
    if (W < 2 || K < 1 || K > W || (W % K) != 0) begin : g_param_check
      $error("serial_addsub_unit: illegal W/K combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [K-1:0]  chunk_a;
  logic [K-1:0]  chunk_b;
  logic [K:0]    chunk_sum;
  logic          msb_cin;
  logic          chunk_ovf;
  logic [W-1:0]  s_next;
  int            base;

  // One slice of the ripple add. The carry into the slice's top bit is
  // recovered from sum = a ^ b ^ cin; on the last slice that bit is W-1,
  // which gives the signed-overflow term. s_next is S with the current
  // slice written in, optionally replaced by the saturated value when the
  // last slice overflows.
  always_comb begin
    base      = int'(cnt) * K;
    chunk_a   = a_reg[base +: K];
    chunk_b   = b_reg[base +: K];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{K{1'b0}}, carry};
    msb_cin   = chunk_a[K-1] ^ chunk_b[K-1] ^ chunk_sum[K-1];
    chunk_ovf = msb_cin ^ chunk_sum[K];
    s_next    = S;
    s_next[base +: K] = chunk_sum[K-1:0];
`ifdef ADDSUB_SAT_EN
    if (cnt == LAST && chunk_ovf) begin
      s_next = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Control FSM with registered handshake outputs. Operands are captured
  // only on the accepting edge (B pre-inverted for subtraction, carry-in
  // set to sub), then N RUN cycles fill S one slice at a time, and DONE
  // holds the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      S         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= A;
            b_reg    <= B ^ {W{sub}};
            carry    <= sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          S     <= s_next;
          carry <= chunk_sum[K];
          if (cnt == LAST) begin
            cout      <= chunk_sum[K];
            ovf       <= chunk_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
